// File: rtl/line_pkg.sv
// Shared constants and types for the line endpoint staging block.
// Holds the default 720p timing, coordinate widths, the packed endpoint
// payload and the staging state encoding.
package line_pkg;

  localparam int unsigned X_W = 11;
  localparam int unsigned Y_W = 10;

  localparam int unsigned H_ACTIVE_DEF = 1280;
  localparam int unsigned V_ACTIVE_DEF = 720;
  localparam int unsigned H_TOTAL_DEF  = 1650;
  localparam int unsigned V_TOTAL_DEF  = 750;

  // One line segment, point 1 always has the smaller (or equal) x.
  typedef struct packed {
    logic [X_W-1:0] x1;
    logic [Y_W-1:0] y1;
    logic [X_W-1:0] x2;
    logic [Y_W-1:0] y2;
  } endpoint_t;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } stage_state_e;

endpackage

// File: rtl/line_endpoint_normalize.sv
// Combinational endpoint normalizer for the line sprite.
// Optionally clamps each coordinate to the visible area, orders the pair so
// x1 <= x2 (ties keep input order) and flags slopes steeper than 45 degrees.
// Optional feature: LINE_ENDPOINT_CLAMP_EN enables clamping to
// H_ACTIVE-1 / V_ACTIVE-1 before the swap decision.
// Ports:
//   xa, ya, xb, yb : raw endpoint pair
//   ep_c           : normalized endpoint pair
//   steep_c        : |y2-y1| > x2-x1 for the normalized pair
module line_endpoint_normalize
  import line_pkg::*;
`ifdef LINE_ENDPOINT_CLAMP_EN
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
)
`endif
(
  input  logic [X_W-1:0] xa,
  input  logic [Y_W-1:0] ya,
  input  logic [X_W-1:0] xb,
  input  logic [Y_W-1:0] yb,
  output endpoint_t      ep_c,
  output logic           steep_c
);

  logic [X_W-1:0] xa_k;
  logic [X_W-1:0] xb_k;
  logic [Y_W-1:0] ya_k;
  logic [Y_W-1:0] yb_k;

`ifdef LINE_ENDPOINT_CLAMP_EN
  localparam logic [X_W-1:0] X_MAX = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_ACTIVE - 1);

  // Saturate to the last visible column/row.
  always_comb begin
    xa_k = (xa > X_MAX) ? X_MAX : xa;
    xb_k = (xb > X_MAX) ? X_MAX : xb;
    ya_k = (ya > Y_MAX) ? Y_MAX : ya;
    yb_k = (yb > Y_MAX) ? Y_MAX : yb;
  end
`else
  always_comb begin
    xa_k = xa;
    xb_k = xb;
    ya_k = ya;
    yb_k = yb;
  end
`endif

  // Order by x; equal x keeps point a as point 1.
  always_comb begin
    if (xa_k > xb_k) begin
      ep_c = '{x1: xb_k, y1: yb_k, x2: xa_k, y2: ya_k};
    end else begin
      ep_c = '{x1: xa_k, y1: ya_k, x2: xb_k, y2: yb_k};
    end
  end

  // 12-bit signed differences of zero-extended values cannot overflow.
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] ady;

  always_comb begin
    dx      = $signed({1'b0, ep_c.x2}) - $signed({1'b0, ep_c.x1});
    dy      = $signed({2'b00, ep_c.y2}) - $signed({2'b00, ep_c.y1});
    ady     = (dy < 0) ? -dy : dy;
    steep_c = (ady > dx);
  end

endmodule

// File: rtl/line_endpoint_staging.sv
// Double-buffered endpoint staging for a line sprite.
// A new endpoint pair is accepted into a one-deep shadow register and only
// becomes visible on the outputs at the frame-end pixel, so the sprite sees
// stable endpoints for a whole frame. A re-init pulse is issued every frame.
// Optional feature: LINE_ENDPOINT_CLAMP_EN (clamp coordinates to the active area).
// Ports:
//   clk_in, rst_in           : pixel clock, synchronous active-high reset
//   hcount_in, vcount_in     : current raster position
//   pt_valid_in/pt_ready_out : endpoint offer handshake (ready = shadow empty)
//   xa_in, ya_in, xb_in, yb_in : raw endpoints
//   x1_out..y2_out           : committed endpoints, x1_out <= x2_out
//   line_rst_out             : one-cycle pulse after every frame end
//   steep_out                : committed slope steeper than the sprite supports
//   commit_out               : one-cycle pulse when new endpoints take effect
module line_endpoint_staging
  import line_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL  = V_TOTAL_DEF
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [X_W-1:0] hcount_in,
  input  logic [Y_W-1:0] vcount_in,
  input  logic           pt_valid_in,
  output logic           pt_ready_out,
  input  logic [X_W-1:0] xa_in,
  input  logic [Y_W-1:0] ya_in,
  input  logic [X_W-1:0] xb_in,
  input  logic [Y_W-1:0] yb_in,
  output logic [X_W-1:0] x1_out,
  output logic [Y_W-1:0] y1_out,
  output logic [X_W-1:0] x2_out,
  output logic [Y_W-1:0] y2_out,
  output logic           line_rst_out,
  output logic           steep_out,
  output logic           commit_out
);

  // Reject timing that cannot be represented by the raster counters.
  if (H_ACTIVE == 0 || H_ACTIVE > H_TOTAL || V_ACTIVE == 0 || V_ACTIVE > V_TOTAL ||
      H_TOTAL > (2 ** X_W) || V_TOTAL > (2 ** Y_W)) begin : g_bad_timing
    $error("line_endpoint_staging: inconsistent timing parameters");
  end

  endpoint_t    norm_ep_c;
  logic         norm_steep_c;

`ifdef LINE_ENDPOINT_CLAMP_EN
  line_endpoint_normalize #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_normalize (
    .xa      (xa_in),
    .ya      (ya_in),
    .xb      (xb_in),
    .yb      (yb_in),
    .ep_c    (norm_ep_c),
    .steep_c (norm_steep_c)
  );
`else
  line_endpoint_normalize u_normalize (
    .xa      (xa_in),
    .ya      (ya_in),
    .xb      (xb_in),
    .yb      (yb_in),
    .ep_c    (norm_ep_c),
    .steep_c (norm_steep_c)
  );
`endif

  stage_state_e state_q, state_d;
  endpoint_t    shadow_q, shadow_d;
  logic         shadow_steep_q, shadow_steep_d;
  endpoint_t    ep_q, ep_d;
  logic         steep_q, steep_d;
  logic         line_rst_q, line_rst_d;
  logic         commit_q, commit_d;
  logic         frame_end_c;

  assign frame_end_c = (hcount_in == X_W'(H_TOTAL - 1)) &&
                       (vcount_in == Y_W'(V_TOTAL - 1));

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= ST_EMPTY;
      shadow_q       <= '0;
      shadow_steep_q <= 1'b0;
      ep_q           <= '0;
      steep_q        <= 1'b0;
      line_rst_q     <= 1'b0;
      commit_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      shadow_steep_q <= shadow_steep_d;
      ep_q           <= ep_d;
      steep_q        <= steep_d;
      line_rst_q     <= line_rst_d;
      commit_q       <= commit_d;
    end
  end

  // Next state: accept into the shadow when empty, publish at frame end.
  // An accept on the frame-end edge only fills the shadow; it is published
  // at the following frame end.
  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    shadow_steep_d = shadow_steep_q;
    ep_d           = ep_q;
    steep_d        = steep_q;
    line_rst_d     = frame_end_c;
    commit_d       = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (pt_valid_in) begin
          shadow_d       = norm_ep_c;
          shadow_steep_d = norm_steep_c;
          state_d        = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_end_c) begin
          ep_d     = shadow_q;
          steep_d  = shadow_steep_q;
          commit_d = 1'b1;
          state_d  = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign pt_ready_out = (state_q == ST_EMPTY);
  assign x1_out       = ep_q.x1;
  assign y1_out       = ep_q.y1;
  assign x2_out       = ep_q.x2;
  assign y2_out       = ep_q.y2;
  assign steep_out    = steep_q;
  assign line_rst_out = line_rst_q;
  assign commit_out   = commit_q;

endmodule
